// File: rtl/cpu_param.sv
// Parametrised multi-cycle accumulator CPU: A/B registers, NZVC flags and a
// single wait-stated memory port shared by fetch, operand and data accesses.
module cpu_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] from_memory,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              write_en,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] to_memory,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_OPERAND, S_MEM_RD, S_MEM_WR, S_EXEC, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0,  OP_LDA_IMM = 4'd1, OP_LDA_DIR = 4'd2;
  localparam logic [3:0] OP_LDB_IMM = 4'd3, OP_LDB_DIR = 4'd4, OP_STA = 4'd5;
  localparam logic [3:0] OP_ADD = 4'd6, OP_SUB = 4'd7, OP_AND = 4'd8, OP_OR = 4'd9;
  localparam logic [3:0] OP_INC = 4'd10, OP_DEC = 4'd11;
  localparam logic [3:0] OP_BRA = 4'd12, OP_BEQ = 4'd13, OP_BCS = 4'd14, OP_HALT = 4'd15;
  localparam int MSB = DATA_W - 1;
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  state_t state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic [DATA_W-1:0] ir_reg, opr_reg, a_reg, b_reg;
  logic [3:0]        ccr_reg;   // {N, Z, V, C}
  logic [3:0]        opcode;

  logic [DATA_W-1:0] alu_opnd, alu_res;
  logic [DATA_W:0]   alu_sum, alu_diff;
  logic              alu_v, alu_c, alu_op, branch_taken;

  assign opcode = ir_reg[3:0];
  assign alu_op = (opcode >= OP_ADD) && (opcode <= OP_DEC);
  assign branch_taken = (opcode == OP_BRA) ||
                        ((opcode == OP_BEQ) && ccr_reg[2]) ||
                        ((opcode == OP_BCS) && ccr_reg[0]);

  // Upper IR/OPR bits are architecturally ignored; keep them visibly consumed.
  logic unused_bits;
  assign unused_bits = ^{ir_reg, opr_reg};

  always_comb begin
    alu_opnd = b_reg;
    if (opcode == OP_INC || opcode == OP_DEC) alu_opnd = ONE;
    alu_sum  = {1'b0, a_reg} + {1'b0, alu_opnd};
    alu_diff = {1'b0, a_reg} - {1'b0, alu_opnd};
    alu_res  = '0;
    alu_v    = 1'b0;
    alu_c    = 1'b0;
    case (opcode)
      OP_ADD, OP_INC: begin
        alu_res = alu_sum[MSB:0];
        alu_c   = alu_sum[DATA_W];
        alu_v   = (a_reg[MSB] == alu_opnd[MSB]) && (alu_sum[MSB] != a_reg[MSB]);
      end
      OP_SUB, OP_DEC: begin
        // The extended top bit of the difference is set exactly when a borrow occurs.
        alu_res = alu_diff[MSB:0];
        alu_c   = alu_diff[DATA_W];
        alu_v   = (a_reg[MSB] != alu_opnd[MSB]) && (alu_diff[MSB] != a_reg[MSB]);
      end
      OP_AND:  alu_res = a_reg & b_reg;
      OP_OR:   alu_res = a_reg | b_reg;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_NOP)       state_next = S_FETCH;
        else if (alu_op)            state_next = S_EXEC;
        else if (opcode == OP_HALT) state_next = S_HALT;
        else                        state_next = S_OPERAND;
      end
      S_OPERAND: begin
        if (mem_ready) begin
          case (opcode)
            OP_LDA_DIR, OP_LDB_DIR: state_next = S_MEM_RD;
            OP_STA:                 state_next = S_MEM_WR;
            OP_BRA, OP_BEQ, OP_BCS: state_next = S_EXEC;
            default:                state_next = S_FETCH;
          endcase
        end
      end
      S_MEM_RD, S_MEM_WR: if (mem_ready) state_next = S_FETCH;
      S_EXEC:   state_next = S_FETCH;
      default:  state_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
      pc_reg    <= RESET_PC;
      ir_reg    <= '0;
      opr_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      ccr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_FETCH: if (mem_ready) begin
          ir_reg <= from_memory;
          pc_reg <= pc_reg + ADDR_W'(1);
        end
        S_OPERAND: if (mem_ready) begin
          opr_reg <= from_memory;
          pc_reg  <= pc_reg + ADDR_W'(1);
          if (opcode == OP_LDA_IMM) a_reg <= from_memory;
          if (opcode == OP_LDB_IMM) b_reg <= from_memory;
        end
        S_MEM_RD: if (mem_ready) begin
          if (opcode == OP_LDA_DIR) a_reg <= from_memory;
          else                      b_reg <= from_memory;
        end
        S_EXEC: begin
          if (alu_op) begin
            a_reg   <= alu_res;
            ccr_reg <= {alu_res[MSB], (alu_res == '0), alu_v, alu_c};
          end else if (branch_taken) begin
            pc_reg <= opr_reg[ADDR_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Port outputs are decoded from state so they stay still through wait cycles.
  always_comb begin
    mem_req   = !rst && (state_reg == S_FETCH || state_reg == S_OPERAND ||
                         state_reg == S_MEM_RD || state_reg == S_MEM_WR);
    write_en  = !rst && (state_reg == S_MEM_WR);
    address   = (state_reg == S_MEM_RD || state_reg == S_MEM_WR) ?
                opr_reg[ADDR_W-1:0] : pc_reg;
    to_memory = (state_reg == S_MEM_WR) ? a_reg : '0;
    halted    = (state_reg == S_HALT);
  end

endmodule

// File: tb/tb_cpu_param.sv
// Directed bench for cpu_param: program table with expected A/CCR/cycle counts,
// plus hand sequences for wait states, branches, PC wrap, HALT and reset abort.
module tb_cpu_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit core with a bench memory model
  logic [7:0] from_memory8, to_memory8, address8;
  logic       ready8, mem_req8, write_en8, halted8;
  logic [7:0] mem8 [256];
  logic [7:0] img  [256];
  int         wr_count = 0;

  cpu_param dut8 (
    .clk(clk), .rst(rst), .from_memory(from_memory8), .mem_ready(ready8),
    .mem_req(mem_req8), .write_en(write_en8), .address(address8),
    .to_memory(to_memory8), .halted(halted8)
  );

  assign from_memory8 = mem8[address8];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem8[i] <= img[i];
    end else if (mem_req8 && ready8 && write_en8) begin
      mem8[address8] <= to_memory8;
    end
    if (mem_req8 && ready8 && write_en8) wr_count <= wr_count + 1;
  end

  // 16-bit core on an all-NOP zero-wait memory, starting near the top of memory
  logic [15:0] from_memory16, to_memory16;
  logic [11:0] address16;
  logic        ready16, mem_req16, write_en16, halted16;

  cpu_param #(.DATA_W(16), .ADDR_W(12), .RESET_PC(12'hFFE)) dut16 (
    .clk(clk), .rst(rst), .from_memory(from_memory16), .mem_ready(ready16),
    .mem_req(mem_req16), .write_en(write_en16), .address(address16),
    .to_memory(to_memory16), .halted(halted16)
  );

  typedef struct {
    logic [127:0] prog;
    int           n;
    int           cycles;
    logic [7:0]   exp_a;
    logic [3:0]   exp_ccr;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addv(input logic [127:0] p, input int n, input int cyc,
                      input logic [7:0] a, input logic [3:0] ccr);
    vec_t v;
    v.prog = p; v.n = n; v.cycles = cyc; v.exp_a = a; v.exp_ccr = ccr;
    vecs.push_back(v);
  endtask

  task automatic load_img(input logic [127:0] p, input int n);
    for (int i = 0; i < 256; i++) img[i] = 8'h0F;
    for (int i = 0; i < n; i++) img[i] = p[8*(n-1-i) +: 8];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, held, base;
    ready8 = 1'b1;
    ready16 = 1'b1;
    from_memory16 = 16'h0000;
    load_img(128'({8'h0F}), 1);

    // Reset state and first fetch
    @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req8), 32'd0);
    chk("rst_write_en", 32'(write_en8), 32'd0);
    chk("rst_mem_req16", 32'(mem_req16), 32'd0);
    rst = 1'b0;
    #1;
    chk("first_addr", 32'(address8), 32'h00);
    chk("first_req", 32'(mem_req8), 32'd1);
    chk("first_we", 32'(write_en8), 32'd0);
    chk("first_tomem", 32'(to_memory8), 32'h00);
    chk("first_halted", 32'(halted8), 32'd0);
    chk("first_a", 32'(dut8.a_reg), 32'h00);
    chk("first_ccr", 32'(dut8.ccr_reg), 32'h0);
    chk("w16_addr0", 32'(address16), 32'hFFE);

    // PC wrap on the 16/12 core: NOP at 0xFFE, NOP at 0xFFF, then 0x000
    step(2);
    chk("w16_addr1", 32'(address16), 32'hFFF);
    step(2);
    chk("w16_addr2", 32'(address16), 32'h000);
    chk("w16_req2", 32'(mem_req16), 32'd1);

    // Table: program bytes, length, cycles from reset release to halted, A, {N,Z,V,C}
    addv(128'({8'h00, 8'h0F}), 2, 4, 8'h00, 4'b0000);
    addv(128'({8'h01, 8'h05, 8'h03, 8'h03, 8'h06, 8'h0F}), 6, 11, 8'h08, 4'b0000);
    addv(128'({8'h01, 8'h7F, 8'h03, 8'h01, 8'h06, 8'h0F}), 6, 11, 8'h80, 4'b1010);
    addv(128'({8'h01, 8'h7F, 8'h03, 8'h01, 8'h06, 8'h03, 8'h80, 8'h07, 8'h0F}), 9, 17, 8'h00, 4'b0100);
    addv(128'({8'h01, 8'h00, 8'h0B, 8'h0F}), 4, 8, 8'hFF, 4'b1001);
    addv(128'({8'h01, 8'hFF, 8'h0A, 8'h0F}), 4, 8, 8'h00, 4'b0101);
    addv(128'({8'h01, 8'h80, 8'h0B, 8'h0F}), 4, 8, 8'h7F, 4'b0010);
    addv(128'({8'h01, 8'hFF, 8'h03, 8'h01, 8'h06, 8'h01, 8'hF0, 8'h03, 8'h3C, 8'h08, 8'h0F}),
         11, 20, 8'h30, 4'b0000);
    addv(128'({8'h01, 8'h81, 8'h03, 8'h02, 8'h09, 8'h0F}), 6, 11, 8'h83, 4'b1000);
    addv(128'({8'h01, 8'h00, 8'h0B, 8'h0E, 8'h20, 8'h01, 8'h55, 8'h0F}), 8, 12, 8'hFF, 4'b1001);
    addv(128'({8'h01, 8'h01, 8'h0D, 8'h20, 8'h01, 8'h66, 8'h0F}), 7, 12, 8'h66, 4'b0000);
    addv(128'({8'h0C, 8'h20, 8'h01, 8'h77, 8'h0F}), 5, 6, 8'h00, 4'b0000);
    addv(128'({8'h02, 8'h0E, 8'h04, 8'h0F, 8'h07, 8'h0F, 8'h0F, 8'h0F,
               8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h10, 8'h03}), 16, 13, 8'h0D, 4'b0000);
    addv(128'({8'h01, 8'hAA, 8'h05, 8'h40, 8'h01, 8'h00, 8'h02, 8'h40, 8'h0F}), 9, 16, 8'hAA, 4'b0000);

    foreach (vecs[i]) begin
      load_img(vecs[i].prog, vecs[i].n);
      do_reset();
      cyc = 0;
      while (!halted8 && cyc < 100) begin
        @(posedge clk);
        cyc++;
        @(negedge clk);
      end
      $display("vec %0d: cycles=%0d A=%02h CCR=%04b", i, cyc, dut8.a_reg, dut8.ccr_reg);
      chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].cycles));
      chk($sformatf("v%0d_a", i), 32'(dut8.a_reg), 32'(vecs[i].exp_a));
      chk($sformatf("v%0d_ccr", i), 32'(dut8.ccr_reg), 32'(vecs[i].exp_ccr));
    end
    chk("v13_mem40", 32'(mem8[8'h40]), 32'hAA);

    // STA 0x40 with three wait cycles: outputs held four cycles, one write
    load_img(128'({8'h01, 8'hAA, 8'h05, 8'h40, 8'h0F}), 5);
    do_reset();
    base = wr_count;
    held = 0;
    cyc = 0;
    while (!halted8 && cyc < 100) begin
      if (write_en8) begin
        held++;
        chk("sta_addr", 32'(address8), 32'h40);
        chk("sta_data", 32'(to_memory8), 32'hAA);
        ready8 = (held >= 4);
      end else begin
        ready8 = 1'b1;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    ready8 = 1'b1;
    $display("sta wait: held=%0d writes=%0d cycles=%0d", held, wr_count - base, cyc);
    chk("sta_held", 32'(held), 32'd4);
    chk("sta_writes", 32'(wr_count - base), 32'd1);
    chk("sta_mem40", 32'(mem8[8'h40]), 32'hAA);
    chk("sta_cycles", 32'(cyc), 32'd12);

    // BCS taken after DEC borrow: next fetch at 0x20
    load_img(128'({8'h01, 8'h00, 8'h0B, 8'h0E, 8'h20}), 5);
    do_reset();
    step(10);
    $display("bcs: address=%02h", address8);
    chk("bcs_addr", 32'(address8), 32'h20);
    chk("bcs_req", 32'(mem_req8), 32'd1);
    chk("bcs_we", 32'(write_en8), 32'd0);

    // BEQ not taken with Z=0: falls through to PC+2
    load_img(128'({8'h01, 8'h01, 8'h0D, 8'h20}), 4);
    do_reset();
    step(7);
    $display("beq: address=%02h", address8);
    chk("beq_addr", 32'(address8), 32'h04);

    // HALT is terminal and ignores mem_ready
    load_img(128'({8'h0F}), 1);
    do_reset();
    step(2);
    chk("halt_flag", 32'(halted8), 32'd1);
    for (int k = 0; k < 4; k++) begin
      ready8 = k[0];
      step(1);
      $display("halt hold %0d: mem_req=%0b halted=%0b", k, mem_req8, halted8);
      chk("halt_req", 32'(mem_req8), 32'd0);
      chk("halt_hold", 32'(halted8), 32'd1);
    end
    ready8 = 1'b1;

    // Reset during a wait-stated MEM_WR: no write, restart at RESET_PC
    load_img(128'({8'h01, 8'hAA, 8'h05, 8'h40, 8'h0F}), 5);
    do_reset();
    base = wr_count;
    cyc = 0;
    while (!write_en8 && cyc < 20) begin
      step(1);
      cyc++;
    end
    ready8 = 1'b0;
    chk("abort_reach_wr", 32'(write_en8), 32'd1);
    step(2);
    chk("abort_wr_held", 32'(write_en8), 32'd1);
    rst = 1'b1;
    ready8 = 1'b1;
    #1;
    chk("abort_req_in_rst", 32'(mem_req8), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    $display("abort: address=%02h mem_req=%0b writes=%0d", address8, mem_req8, wr_count - base);
    chk("abort_addr", 32'(address8), 32'h00);
    chk("abort_req", 32'(mem_req8), 32'd1);
    chk("abort_writes", 32'(wr_count - base), 32'd0);
    chk("abort_a", 32'(dut8.a_reg), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_param.md
# cpu_param

Parametrised multi-cycle accumulator CPU core: fetches, decodes and executes a 16-opcode A/B-register instruction set against a single shared memory port. It supersedes the fixed 8-bit CPU top by making data and address widths configurable. It adds a wait-state memory handshake, a HALT state and a full NZVC condition-code register. It sits between the memory/bus block and nothing else, and is the only master on the memory port.

## Interface
- DATA_W, 8: data and instruction word width; must be ≥ 8.
- ADDR_W, 8: address width; must be ≤ DATA_W.
- RESET_PC, 0: PC value loaded on reset (ADDR_W bits).

- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- from_memory  input  DATA_W  read data; valid when mem_ready=1 during a read access.
- mem_ready  input  1  access completes on the rising edge where mem_req=1 and mem_ready=1.
- mem_req  output  1  access in progress; address/to_memory/write_en stable while high.
- write_en  output  1  1 = write access, 0 = read; only meaningful with mem_req=1.
- address  output  ADDR_W  access address.
- to_memory  output  DATA_W  write data (= A during store, 0 otherwise).
- halted  output  1  core executed HALT.

## Operation
- Registers:
  - PC (ADDR_W);
  - IR, OPR, A, B (DATA_W);
  - CCR {N,Z,V,C}.
- Opcode = IR[3:0]; IR upper bits ignored.
- Opcodes:
  - 0 NOP.
  - 1 LDA #imm; 2 LDA dir; 3 LDB #imm; 4 LDB dir.
  - 5 STA dir.
  - 6 ADD A←A+B; 7 SUB A←A−B; 8 AND; 9 OR; 10 INC A; 11 DEC A.
  - 12 BRA; 13 BEQ (Z=1); 14 BCS (C=1).
  - 15 HALT.
- Opcodes 1–5 and 12–14 take one operand word following the opcode. A direct address is OPR[ADDR_W-1:0].
- States:
  - FETCH: read at PC. On completion IR←from_memory, PC←PC+1, go DECODE.
  - DECODE:
    - 0 → FETCH;
    - 6–11 → EXEC;
    - 15 → HALT;
    - all others → OPERAND.
  - OPERAND: read at PC. On completion OPR←from_memory, PC←PC+1.
    - Immediate loads write A/B here, then → FETCH.
    - 2/4 → MEM_RD; 5 → MEM_WR; 12–14 → EXEC.
  - MEM_RD: read at OPR address. On completion A or B←from_memory, → FETCH.
  - MEM_WR: write A to OPR address (write_en=1). On completion → FETCH.
  - EXEC: ALU op or branch (PC←OPR[ADDR_W-1:0] if taken), → FETCH.
  - HALT: terminal until rst; mem_req=0, halted=1.
- Flags: updated only by opcodes 6–11; loads, stores and branches leave CCR unchanged.
  - N = result MSB.
  - Z = (result==0).
  - ADD/INC: C = carry out of bit DATA_W-1; V = signed overflow.
  - SUB/DEC: C = borrow (1 when unsigned A<subtrahend); V = signed overflow.
  - AND/OR: V=0, C=0.
- Arithmetic is modulo 2^DATA_W. PC increments modulo 2^ADDR_W: PC=2^ADDR_W−1 wraps to 0.

## Timing
- Each access state holds until the edge with mem_ready=1. Zero-wait memory (mem_ready tied 1) completes every access in one cycle.
- Each wait cycle adds exactly one cycle; outputs stay unchanged through waits.
- Zero-wait latencies (cycles from FETCH entry to next FETCH entry):
  - NOP 2;
  - ALU ops 3;
  - immediate loads 3;
  - direct loads, STA, branches 4.
- Outputs are combinational from state/registers, forced mem_req=0 and write_en=0 while rst=1.
- Reset values: PC=RESET_PC; A=B=IR=OPR=0; CCR=0; state FETCH; halted=0; to_memory=0.
- First fetch (address=RESET_PC, mem_req=1) appears in the first cycle with rst=0.
- rst mid-access (including during wait cycles or HALT) aborts immediately. No write completes on an edge where rst=1.
- mem_ready while mem_req=0 is ignored.

## Test plan
- Reset then LDA #0x05 (0x01,0x05), LDB #0x03, ADD, zero-wait → A=0x08, CCR=0000, ADD retires 3 cycles after its fetch.
- LDA #0x7F, LDB #0x01, ADD → A=0x80, N=1 V=1 Z=0 C=0; then SUB with B=0x80 → A=0x00, Z=1, C=0.
- LDA #0xAA, STA 0x40 with mem_ready low 3 cycles → write_en=1, address=0x40, to_memory=0xAA held 4 cycles, exactly one write.
- LDA #0x00, DEC, BCS 0x20 (C=1 from borrow) → next fetch address 0x20; BEQ with Z=0 → falls through to PC+2.
- DATA_W=16, ADDR_W=12, RESET_PC=0xFFE: NOP at 0xFFE, NOP at 0xFFF → third fetch at 0x000.
- HALT → halted=1, mem_req=0 indefinitely; assert rst during wait-stated MEM_WR → no write, fetch restarts at RESET_PC.
